button_event: RTL
=================

Name: button_event

Overview:
- Sits directly downstream of the button debouncer; consumes its clean, level-type button signal.
- Converts the level into single-cycle event pulses for the game controller: press, release, long-press, and auto-repeat while held.
- Also provides a held level.
- All timing derives from the same clk_freq parameter the debouncer uses, so both blocks are configured identically.

Parameters:
clk_freq, 50_000_000, clock frequency in Hz
long_ms, 1000, hold time in ms before long_press fires
repeat_ms, 200, auto-repeat period in ms after long_press
(derived localparams) LONG_CYCLES = clk_freq/1000*long_ms; REP_CYCLES = clk_freq/1000*repeat_ms; both must be >= 1 (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
btn  input  1  debounced button level (1 = pressed)
press  output  1  one-cycle pulse on accepted press
release  output  1  one-cycle pulse when the button is released
long_press  output  1  one-cycle pulse once per hold, after LONG_CYCLES
repeat  output  1  one-cycle pulse every REP_CYCLES while held past long_press
held  output  1  level, 1 while state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Outputs and registers:
  - All outputs are registered.
  - Pulse outputs default to 0 every cycle unless set below.
  - 32-bit cycle counter cnt; btn_q holds the previous-cycle btn.
- Reset values: press, release, long_press, repeat, held = 0; state = IDLE; cnt = 0; btn_q = 1.
  - Because btn_q resets to 1, a button held through reset produces no press. A new press requires btn to be seen low first.
- State IDLE:
  - If btn=1 and btn_q=0: go to PRESSED, cnt<=0, press<=1.
  - Otherwise stay in IDLE.
- State PRESSED:
  - If btn=0: go to IDLE, release<=1, cnt<=0.
  - Else if cnt==LONG_CYCLES-1: go to LONG, long_press<=1, cnt<=0.
  - Else cnt<=cnt+1.
- State LONG:
  - If btn=0: go to IDLE, release<=1, cnt<=0.
  - Else if cnt==REP_CYCLES-1: repeat<=1, cnt<=0.
  - Else cnt<=cnt+1.
- held: registered, equal to (next state != IDLE). It rises in the same cycle as press and falls in the same cycle as release.
- Timing:
  - press is visible 1 cycle after the first sampled btn=1.
  - long_press is visible exactly LONG_CYCLES cycles after press.
  - The first repeat is REP_CYCLES cycles after long_press, then every REP_CYCLES cycles.
- Priority: release beats long_press/repeat on the same edge. If btn drops in the cycle the threshold is reached, only release fires.
- Mutual exclusion: press, release, long_press and repeat are never high together; at most one is asserted per cycle.
- Short press: a press shorter than LONG_CYCLES produces press and release only.
- Glitch handling: a 1-cycle btn high produces press then release on consecutive cycles. No filtering is done here; filtering is the debouncer's job.
- Counter: cnt never exceeds max(LONG_CYCLES, REP_CYCLES)-1, so no wrap-around is possible. A long hold keeps repeating indefinitely.
- Reset mid-operation: rst asserted in any state returns all registers to their reset values on the next edge, with no release pulse.
- Repeat period of one: REP_CYCLES=1 makes repeat high every cycle while in LONG.

Test Plan:
1. Sim config: clk_freq=1000, long_ms=10, repeat_ms=4, so LONG_CYCLES=10 and REP_CYCLES=4.
2. Reset release with btn=0, then btn high for 3 cycles -> press pulse 1 cycle after btn rise; held=1 for 3 cycles; release pulse on the cycle held falls; no long_press.
3. btn held for 25 cycles -> press at t; long_press at t+10; repeat at t+14, t+18, t+22; release 1 cycle after btn falls; exactly one long_press.
4. btn falls on the exact cycle cnt==9 in PRESSED -> release only, no long_press; state back to IDLE.
5. btn=1 held across rst assertion and deassertion -> no press while still held; drop btn for 1 cycle and raise it -> press fires once.
6. Assert rst during LONG while repeats are occurring -> all outputs 0 on the next edge, no release pulse; with btn=0 then 1 afterwards, normal press follows.

Source files
------------

// File: rtl/button_event.sv
// button_event: turns the debounced button level into single-cycle event
// pulses (press, release, long-press, auto-repeat) plus a held level.
//
// Handshake: there is no valid/ready pair here. btn is a free-running
// level sampled on every rising clk edge. Each event output is a one-cycle
// pulse with no backpressure, and at most one event pulse is high in any cycle.
//
// "release" and "repeat" are reserved words in SystemVerilog, so those
// event outputs are named release_evt and repeat_evt.
module button_event #(
  parameter int unsigned clk_freq  = 50_000_000,
  parameter int unsigned long_ms   = 1000,
  parameter int unsigned repeat_ms = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       press,
  output logic       release_evt,
  output logic       long_press,
  output logic       repeat_evt,
  output logic       held,
  output logic [1:0] state_dbg
);

  localparam int unsigned LONG_CYCLES = clk_freq / 1000 * long_ms;
  localparam int unsigned REP_CYCLES  = clk_freq / 1000 * repeat_ms;

  // A zero-length hold or repeat period is meaningless, so elaboration stops.
  generate
    if (LONG_CYCLES < 1) begin : g_bad_long
      $error("button_event: LONG_CYCLES must be >= 1");
    end
    if (REP_CYCLES < 1) begin : g_bad_rep
      $error("button_event: REP_CYCLES must be >= 1");
    end
  endgenerate

  // Terminal counts. cnt counts 0..LAST, so it never exceeds
  // max(LONG_CYCLES, REP_CYCLES)-1 and cannot wrap.
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] REP_LAST  = 32'(REP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        btn_q;
  logic        press_nxt, release_nxt, long_nxt, repeat_nxt;

  // Register the state, counter, previous btn and every output.
  // btn_q resets to 1, so a button still held across reset is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_q       <= 1'b1;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_q       <= btn;
      press       <= press_nxt;
      release_evt <= release_nxt;
      long_press  <= long_nxt;
      repeat_evt  <= repeat_nxt;
      held        <= (state_nxt != IDLE);
    end
  end

  // Next-state and event decode. Release is checked first in each active
  // state, so a drop on the threshold cycle yields only release.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (btn && !btn_q) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      LONG: begin
        if (!btn) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (cnt == REP_LAST) begin
          cnt_nxt    = '0;
          repeat_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule
